mult_iter_n: RTL
================

// Module: mult_iter_n
// PURPOSE
//  Parametrised iterative multiplier; next generation of the fixed 32x32 shift-add mult.
//  Adds configurable operand width, configurable bits-per-cycle, per-operation signed/unsigned
//  mode, back-to-back issue, and a busy flag. Sits beside the datapath as a multi-cycle unit
//  driven by a one-cycle 'mult' request and answered by a one-cycle 'en' pulse.
// PARAMETERS
//  WIDTH      32  operand width in bits; product width is 2*WIDTH
//  STEP       1   multiplier bits consumed per CALC cycle; legal 1,2,4; WIDTH % STEP == 0
//  SIGNED_EN  1   1: signed_mode honoured; 0: signed_mode ignored, always unsigned
// PORTS
//  m_clock      in   1        clock, all state updates on rising edge
//  p_reset      in   1        reset, synchronous, active-high
//  a            in   WIDTH    multiplicand, sampled on accepted request
//  b            in   WIDTH    multiplier, sampled on accepted request
//  mult         in   1        request strobe; accepted when state is IDLE or DONE
//  signed_mode  in   1        1: a,b,out two's complement; sampled with a,b
//  out          out  2*WIDTH  product register; holds last result until next completion
//  en           out  1        one-cycle pulse: out valid this cycle
//  busy         out  1        high in CALC and FIX
// BEHAVIOUR
//  - Reset (p_reset high at edge): state=IDLE, out=0, en=0, busy=0, internal regs 0. Reset
//    mid-operation abandons it: no en pulse, out keeps 0.
//  - FSM: IDLE -mult-> CALC; CALC loops N=WIDTH/STEP cycles (counter N-1..0) -> FIX -> DONE;
//    DONE -mult-> CALC (back-to-back) else -> IDLE. en = (state==DONE), registered.
//  - Latency: mult high in cycle t -> CALC t+1..t+N, FIX t+N+1, en high in t+N+2.
//    WIDTH=32,STEP=1: t+34. Throughput with back-to-back issue: one result per N+2 cycles.
//  - mult while busy is ignored (dropped, no queueing, no error). mult in DONE cycle accepted.
//  - Accept: latch |a|,|b| magnitudes (signed mode: negate if MSB set) and result sign
//    neg = a[MSB]^b[MSB]; unsigned: magnitudes are raw values, neg=0.
//  - CALC: acc(2*WIDTH) += (|a| * low STEP bits of |b|) << (STEP*iter); |b| shifts right STEP.
//    Unsigned arithmetic, 2*WIDTH bits, no overflow possible (|a|,|b| <= 2^WIDTH-1 or 2^(WIDTH-1)).
//  - FIX: out <= neg ? -acc : acc (2*WIDTH two's complement). out updated only here.
//  - Boundary: most-negative*most-negative (signed) = 2^(2*WIDTH-2), positive, fits.
//    Zero operand: full N cycles still taken, out=0, neg result of -0 yields 0.
//  - Inputs a,b,signed_mode may change freely after accept cycle without effect.
// STRUCTURE
//  - Shared package mult_pkg: state enum {IDLE,CALC,FIX,DONE}, legal-STEP check constant,
//    helper function for magnitude/negate.
//  - One sub-module natural: mult_pp_step (combinational: acc, |a|, STEP-bit digit, shift
//    -> next acc). Counter, operand regs and FSM stay in mult_iter_n.
//  - Elaboration error if WIDTH % STEP != 0 or STEP not in {1,2,4}.
// TESTING
//  1 Reset: hold p_reset 2 cycles -> out=0, en=0, busy=0; drive mult during reset -> ignored.
//  2 WIDTH=32,STEP=1 unsigned: a=b=0xFFFFFFFF, mult at t -> busy t+1..t+33,
//    en only at t+34, out=0xFFFFFFFE00000001.
//  3 Signed: 0x80000000*0x80000000 -> 0x4000000000000000; 0xFFFFFFFD*0x00000005 (-3*5)
//    -> 0xFFFFFFFFFFFFFFF1; same -3*5 with signed_mode=0 -> 0x00000004FFFFFFF1.
//  4 Handshake: mult pulsed at t+5 while busy -> dropped, exactly one en; mult in en cycle
//    t+34 with 7*6 -> next en at t+68, out=42; out stays prior value t+35..t+67.
//  5 Reset mid-op: mult at t, p_reset at t+10 -> no en ever, busy=0 from t+11, out=0.
//  6 WIDTH=8,STEP=4,signed: 0x7F*0x81 (127*-127) -> en at t+4, out=0xC0FF; plus
//    2000-vector random sweep per config vs reference model, 0 fails.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier family.
package mult_pkg;

  // Controller states: accept in IDLE/DONE, iterate in CALC, apply sign in FIX.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Widest value the negate helper handles (product of two 64-bit operands).
  localparam int MAX_W = 128;

  // Legal parameter combinations: STEP in {1,2,4}, WIDTH a multiple of STEP.
  function automatic bit step_legal(input int width, input int step);
    return ((step == 1) || (step == 2) || (step == 4)) &&
           (width > 0) && (width <= 64) && ((width % step) == 0);
  endfunction

  // Two's complement negate when neg is set. Callers truncate the result to
  // their own width; modular negation keeps the low bits correct.
  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] x,
                                              input logic             neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One shift-add iteration: acc + (|a| * digit) << (STEP * iter).
module mult_pp_step
  #(parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CNT_W = 5)
  (input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   a_mag_i,
   input  logic [STEP-1:0]    digit_i,
   input  logic [CNT_W-1:0]   iter_i,
   output logic [2*WIDTH-1:0] acc_o);

  localparam int PW   = 2 * WIDTH;
  localparam int SH_W = CNT_W + 3;

  logic [PW-1:0]   pp;
  logic [SH_W-1:0] shamt;

  // Partial product of the current digit, aligned to its bit position.
  always_comb begin
    pp    = PW'(a_mag_i) * PW'(digit_i);
    shamt = SH_W'(iter_i) * SH_W'(STEP);
    acc_o = acc_i + (pp << shamt);
  end

endmodule

// File: rtl/mult_iter_n.sv
// Parametrised iterative multiplier: STEP multiplier bits per cycle, optional
// signed mode, back-to-back issue from DONE, one-cycle en pulse per result.
module mult_iter_n
  import mult_pkg::*;
  #(parameter int WIDTH     = 32,
    parameter int STEP      = 1,
    parameter int SIGNED_EN = 1)
  (input  logic               m_clock,
   input  logic               p_reset,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               mult,
   input  logic               signed_mode,
   output logic [2*WIDTH-1:0] out,
   output logic               en,
   output logic               busy);

  localparam int PW    = 2 * WIDTH;
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!step_legal(WIDTH, STEP)) begin : g_bad_param
    $error("mult_iter_n: STEP must be 1, 2 or 4 and divide WIDTH (WIDTH <= 64)");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] amag_q, amag_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    out_q, out_d;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CNT_W-1:0] iter;
  logic [PW-1:0]    acc_next;

  // Operand magnitudes and result sign, computed from the live inputs so they
  // can be latched in the accept cycle.
  assign sgn   = (SIGNED_EN != 0) && signed_mode;
  assign a_mag = WIDTH'(neg_if(MAX_W'(a), sgn & a[WIDTH-1]));
  assign b_mag = WIDTH'(neg_if(MAX_W'(b), sgn & b[WIDTH-1]));
  assign iter  = LAST - cnt_q;

  mult_pp_step #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) u_pp_step (
    .acc_i   (acc_q),
    .a_mag_i (amag_q),
    .digit_i (bmag_q[STEP-1:0]),
    .iter_i  (iter),
    .acc_o   (acc_next)
  );

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    amag_d  = amag_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mult) begin
          state_d = CALC;
          cnt_d   = LAST;
          amag_d  = a_mag;
          bmag_d  = b_mag;
          neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
        end
      end
      CALC: begin
        acc_d  = acc_next;
        bmag_d = bmag_q >> STEP;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        out_d   = PW'(neg_if(MAX_W'(acc_q), neg_q));
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge m_clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    if (p_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amag_q  <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      amag_q  <= amag_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign en   = (state_q == DONE);
  assign busy = (state_q == CALC) || (state_q == FIX);

endmodule
